// File: rtl/nn_pkg.sv
// +--------------------------------------------------------------------------+
// | nn_pkg - shared types for the classifier output stage                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package nn_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    EMIT    = 2'd1,
    HOLDOFF = 2'd2
  } packer_state_t;

  // Idle cycles the argmax scan needs after each valid pulse.
  function automatic int unsigned holdoff_cycles(input int unsigned num_input);
    return num_input + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/score_packer.sv
// +--------------------------------------------------------------------------+
// | score_packer - serial score beats packed into one frame for argmax,      |
// | with optional frame spacing (macro SCORE_PACKER_HOLDOFF_EN)              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module score_packer
  import nn_pkg::*;
#(
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [INPUT_WIDTH-1:0]           i_data,
  input  logic                             i_valid,
  input  logic                             i_last,
  output logic                             o_ready,
  output logic [NUM_INPUT*INPUT_WIDTH-1:0] o_data,
  output logic                             o_data_valid,
  output logic                             o_frame_err
);

  localparam int              c_cnt_w    = $clog2(NUM_INPUT);
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(NUM_INPUT - 1);

  packer_state_t                      r_state;
  logic [c_cnt_w-1:0]                 r_beat_cnt;
  logic [NUM_INPUT*INPUT_WIDTH-1:0]   r_data;
  logic                               r_valid;
  logic                               r_err;
  logic                               w_accept;
  logic                               w_at_end;

`ifdef SCORE_PACKER_HOLDOFF_EN
  localparam int                  c_hold_w    = $clog2(NUM_INPUT + 1);
  localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(holdoff_cycles(NUM_INPUT) - 1);
  logic [c_hold_w-1:0]            r_hold;
`endif

  // Reset gates ready combinationally so no beat is taken while held in reset.
  assign o_ready      = i_rst_n && (r_state == COLLECT);
  assign w_accept     = i_valid && o_ready;
  assign w_at_end     = (r_beat_cnt == c_last_idx);
  assign o_data       = r_data;
  assign o_data_valid = r_valid;
  assign o_frame_err  = r_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= COLLECT;
      r_beat_cnt <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
`ifdef SCORE_PACKER_HOLDOFF_EN
      r_hold     <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_accept) begin
            for (int k = 0; k < NUM_INPUT; k++) begin
              if (r_beat_cnt == c_cnt_w'(k)) begin
                r_data[k*INPUT_WIDTH +: INPUT_WIDTH] <= i_data;
              end
            end
            // Frame closes on i_last or on the slot limit; only both together is good.
            if (w_at_end || i_last) begin
              r_beat_cnt <= '0;
              if (w_at_end && i_last) begin
                r_state <= EMIT;
                r_valid <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        EMIT: begin
`ifdef SCORE_PACKER_HOLDOFF_EN
          r_state <= HOLDOFF;
          r_hold  <= c_hold_load;
`else
          r_state <= COLLECT;
`endif
        end
`ifdef SCORE_PACKER_HOLDOFF_EN
        HOLDOFF: begin
          if (r_hold <= c_hold_w'(1)) begin
            r_state <= COLLECT;
            r_hold  <= '0;
          end else begin
            r_hold  <= r_hold - 1'b1;
          end
        end
`endif
        default: begin
          r_state <= COLLECT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_packer.sv
// +--------------------------------------------------------------------------+
// | tb_score_packer - scoreboard bench for score_packer                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_score_packer;

  localparam int N  = 10;
  localparam int W  = 16;
  localparam int DW = N * W;
`ifdef SCORE_PACKER_HOLDOFF_EN
  localparam int EXP_LOW = N + 1;
  localparam int EXP_GAP = N + 2;
`else
  localparam int EXP_LOW = 1;
  localparam int EXP_GAP = 2;
`endif

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [W-1:0]  i_data = '0;
  logic          i_valid = 1'b0;
  logic          i_last = 1'b0;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_frame_err;

  score_packer #(.NUM_INPUT(N), .INPUT_WIDTH(W)) dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_frame_err  (o_frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit            is_err;
    logic [DW-1:0] data;
    int            idx;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Consumer view: index of the first maximum score.
  function automatic int argmax_of(input logic [DW-1:0] d);
    int best = 0;
    for (int k = 1; k < N; k++)
      if (d[k*W +: W] > d[best*W +: W]) best = k;
    return best;
  endfunction

  // Monitor: pops expectations on each output event, tracks ready spacing.
  bit            trk = 0;
  int            lowcnt = 0;
  logic [DW-1:0] snap;
  always @(negedge clk) begin
    if (i_rst_n) begin
      if (o_data_valid || o_frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_output", {o_data_valid, o_frame_err}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_kind", DW'({o_data_valid, o_frame_err}), e.is_err ? DW'(2'b01) : DW'(2'b10));
          if (!e.is_err) begin
            chk("frame_data", o_data, e.data);
            chk("argmax_idx", DW'(argmax_of(o_data)), DW'(e.idx));
          end
        end
      end
      if (o_data_valid) begin
        trk    = 1;
        lowcnt = 0;
        snap   = o_data;
      end
      if (trk) begin
        if (!o_ready) begin
          lowcnt++;
          chk("data_stable", o_data, snap);
        end else begin
          chk("ready_low_cycles", DW'(lowcnt), DW'(EXP_LOW));
          trk = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
  endtask

  // Presents a beat; returns (before the edge) once it will be accepted.
  task automatic send_beat(input logic [W-1:0] d, input bit last, output int acc);
    int w = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    i_last  = last;
    while (!o_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_timeout", DW'(o_ready), DW'(1));
    acc = o_ready ? cyc + 1 : -1;
  endtask

  // mode: 0 random, 1 ramp 1..n, 2 constant 0x1234
  task automatic send_frame(input int nb, input bit last_final, input int mode,
                            input int gapmax, input bit keep,
                            output int first_acc, output int last_acc);
    logic [DW-1:0] exp_d = '0;
    int            vals[N];
    int            acc;
    int            best;
    for (int b = 0; b < nb; b++) begin
      int v;
      if (b > 0 && gapmax > 0) idle($urandom_range(0, gapmax));
      v = (mode == 1) ? b + 1 : (mode == 2) ? 32'h1234 : int'($urandom_range(0, 65535));
      vals[b] = v;
      exp_d   = exp_d | (DW'(v) << (b * W));
      send_beat(W'(v), (b == nb - 1) && last_final, acc);
      if (b == 0) first_acc = acc;
      last_acc = acc;
    end
    if (nb == N && last_final) begin
      best = 0;
      for (int k = 1; k < N; k++) if (vals[k] > vals[best]) best = k;
      q.push_back('{is_err: 1'b0, data: exp_d, idx: best});
    end else begin
      q.push_back('{is_err: 1'b1, data: '0, idx: 0});
    end
    if (!keep) idle(1);
  endtask

  initial begin
    int f1, l1, f2, l2, acc;
    repeat (3) @(negedge clk);
    chk("rst_data", o_data, '0);
    chk("rst_ready", DW'(o_ready), DW'(0));
    chk("rst_valid", DW'({o_data_valid, o_frame_err}), DW'(0));
    i_rst_n = 1'b1;
    #1 chk("ready_after_rst", DW'(o_ready), DW'(1));

    // ramp frame
    send_frame(N, 1, 1, 0, 0, f1, l1);
    idle(2);
    chk("slice0", DW'(o_data[15:0]), DW'(16'h0001));
    chk("slice9", DW'(o_data[159:144]), DW'(16'h000A));
    idle(N + 2);

    // two frames with valid held continuously
    send_frame(N, 1, 0, 0, 1, f1, l1);
    send_frame(N, 1, 0, 0, 0, f2, l2);
    chk("frame_gap", DW'(f2 - l1), DW'(EXP_GAP));
    idle(N + 2);

    // short frame then constant frame
    send_frame(5, 1, 0, 0, 0, f1, l1);
    send_frame(N, 1, 2, 0, 0, f1, l1);
    idle(N + 2);

    // long frame then good frame
    send_frame(N, 0, 0, 0, 0, f1, l1);
    send_frame(N, 1, 0, 1, 0, f1, l1);
    idle(N + 2);

    // reset mid-frame after beat 5
    for (int b = 0; b < 6; b++) send_beat(W'($urandom_range(0, 65535)), 1'b0, acc);
    @(negedge clk);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_data", o_data, '0);
    chk("midrst_ready", DW'(o_ready), DW'(0));
    chk("midrst_flags", DW'({o_data_valid, o_frame_err}), DW'(0));
    i_rst_n = 1'b1;
    #1 chk("midrst_ready_after", DW'(o_ready), DW'(1));
    send_frame(N, 1, 0, 0, 0, f1, l1);
    idle(N + 2);

    // random mix
    for (int i = 0; i < 30; i++) begin
      int kind = $urandom_range(0, 3);
      if (kind == 0)      send_frame($urandom_range(1, N - 1), 1, 0, 2, 0, f1, l1);
      else if (kind == 1) send_frame(N, 0, 0, 2, 0, f1, l1);
      else                send_frame(N, 1, 0, 2, $urandom_range(0, 1), f1, l1);
    end
    idle(3 * N);
    chk("pending_expected", DW'(q.size()), DW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/score_packer.md
# score_packer

Front end of the output-classification stage. Accepts the final layer's neuron outputs as a serial valid/ready stream, one score per beat. Packs them into the flat `NUM_INPUT*INPUT_WIDTH` bus and raises a single-cycle valid for the argmax finder. Because the argmax finder restarts its scan on every valid pulse, the packer also spaces frames so that no frame is launched while the previous scan is still running.

## Interface
- `NUM_INPUT`, default 10: scores per frame (neuron count); must be ≥ 2.
- `INPUT_WIDTH`, default 16: bits per score, unsigned.
- `i_clk`, in, 1: the single clock. All logic is on its rising edge.
- `i_rst_n`, in, 1: synchronous, active-low reset.
- `i_data`, in, `INPUT_WIDTH`: score beat.
- `i_valid`, in, 1: the beat is present.
- `i_last`, in, 1: marks the final beat of a frame.
- `o_ready`, out, 1: the packer accepts a beat this cycle.
- `o_data`, out, `NUM_INPUT*INPUT_WIDTH`: packed frame.
- `o_data_valid`, out, 1: one-cycle pulse; `o_data` holds a complete frame.
- `o_frame_err`, out, 1: one-cycle pulse; a malformed frame was discarded.

## Operation
- A beat is accepted when `i_valid && o_ready`.
- Beat k of a frame (k = 0..`NUM_INPUT`-1) is written to `o_data[k*INPUT_WIDTH +: INPUT_WIDTH]`. Beat 0 goes in the LSB slice, which is index 0 for the argmax finder.
- `beat_cnt` has width `$clog2(NUM_INPUT)` and counts accepted beats in the current frame.
- FSM states:
  - `COLLECT`: `o_ready`=1. On each accepted beat, store the slice and increment `beat_cnt`.
    - Accepted beat with `beat_cnt`==`NUM_INPUT`-1 and `i_last`=1: go to `EMIT`, clear `beat_cnt`.
    - Accepted beat with `i_last`=1 and `beat_cnt`<`NUM_INPUT`-1 (short frame): pulse `o_frame_err`, clear `beat_cnt`, stay in `COLLECT`.
    - Accepted beat with `beat_cnt`==`NUM_INPUT`-1 and `i_last`=0 (long frame): pulse `o_frame_err`, clear `beat_cnt`, stay in `COLLECT`.
    - A discarded frame never produces `o_data_valid`. Partially written slices are don't-care until the next good frame overwrites them.
  - `EMIT`: `o_ready`=0, `o_data_valid`=1 for exactly this cycle. Next state is `HOLDOFF` (macro defined) or `COLLECT` (macro undefined).
  - `HOLDOFF`: `o_ready`=0. A down-counter loaded with `NUM_INPUT` runs; return to `COLLECT` when it reaches 0.
- `o_data` is a register. It is updated only by accepted beats and must stay stable from `EMIT` until the first beat of the next frame.
- `i_valid` while `o_ready`=0 is ignored. The beat is not consumed and no error is raised.
- Reset (synchronous, `i_rst_n`=0 at a rising edge) from any state:
  - State goes to `COLLECT` and `beat_cnt` goes to 0.
  - `o_data` goes to 0, `o_data_valid` to 0, `o_frame_err` to 0.
  - `o_ready` is 0 while `i_rst_n`=0 and 1 on the first cycle after release.
  - A frame in flight at reset is dropped silently, with no error pulse.

## Timing
- Last good beat accepted at edge t: `o_data_valid`=1 and the complete `o_data` are visible during cycle t+1.
- `o_frame_err` is visible during the cycle after the offending beat is accepted.
- With holdoff: `o_ready`=0 for cycles t+1 .. t+1+`NUM_INPUT`. The earliest next beat is accepted at edge t+2+`NUM_INPUT`. This guarantees `NUM_INPUT`+1 idle cycles after the valid pulse, which the argmax scan needs.
- Without holdoff: `o_ready`=0 only in cycle t+1. The next beat can be accepted at edge t+2.
- Maximum throughput in `COLLECT` is one beat per cycle. `o_ready` does not depend combinationally on `i_valid`.

## Configuration
- Macro: `SCORE_PACKER_HOLDOFF_EN`.
- Defined: the `HOLDOFF` state and its counter are compiled in, with timing as above. This is the default in the top-level build.
- Undefined: `HOLDOFF` and its counter are removed and `EMIT` returns directly to `COLLECT`. Use this only when the consumer is non-restarting or buffered.

## Structure
- Shared package `nn_pkg`:
  - State enum `packer_state_t` (`COLLECT`, `EMIT`, `HOLDOFF`).
  - Function `holdoff_cycles(num_input)`, which returns `num_input`+1, so the packer and the argmax finder agree on the spacing.
- Sub-module: none. The holdoff counter stays inline.

## Test plan
- Default parameters (`NUM_INPUT`=10, `INPUT_WIDTH`=16). Stream 10 beats of values 0x0001..0x000A with back-to-back valid, `i_last` on beat 9:
  - `o_data_valid` pulses one cycle after beat 9.
  - `o_data[15:0]`=0x0001 and `o_data[159:144]`=0x000A.
  - The consumer reports index 9.
- `i_valid` held high continuously across two frames with holdoff enabled: `o_ready` is low for exactly 11 cycles starting at the valid pulse, and frame 2's first beat is accepted 12 cycles after frame 1's last beat.
- Short frame, `i_last` on beat 4: `o_frame_err` pulses once, there is no `o_data_valid`, and a following good frame of all 0x1234 packs correctly.
- Long frame, beat 9 with `i_last`=0: `o_frame_err` pulses, there is no valid, and `beat_cnt` returns to 0.
- `i_rst_n` low for one cycle after beat 5 of a frame:
  - All outputs read 0 during the reset cycle.
  - `o_ready`=1 on the next cycle.
  - A fresh 10-beat frame emits normally with no error.
- Build with `SCORE_PACKER_HOLDOFF_EN` undefined: a second frame's first beat is accepted 2 cycles after the first frame's last beat.
